shift_arbiter_2ch: RTL and testbench

Two-requester arbiter and sequencer for one shared 8-bit left/right rotating barrel shifter (`barrel_shifter_lr_8b`). Each requester offers an operand, direction and amount over a valid/ready handshake. The block grants round-robin, runs the operation through the single shifter instance, and returns the result tagged with the requester ID over a valid/ready output port. It sits between board-level or sequencing logic and the combinational shifter datapath.

---
 rtl/shift_arb_pkg.sv | 14 +
 rtl/barrel_shifter_lr_8b.sv | 22 ++
 rtl/shift_arbiter_2ch.sv | 153 +++++++++++++++
 tb/tb_shift_arbiter_2ch.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_arb_pkg.sv
// Shared types and widths for the two-channel shift arbiter.
package shift_arb_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned AMT_W  = 3;
  localparam int unsigned ID_W   = 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } arb_state_t;

endpackage

// File: rtl/barrel_shifter_lr_8b.sv
// 8-bit rotating barrel shifter, left (lr=1) or right (lr=0) by 0..7.
module barrel_shifter_lr_8b
  import shift_arb_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic              lr,
  input  logic [AMT_W-1:0]  amt,
  output logic [DATA_W-1:0] y
);

  logic [AMT_W-1:0]  w_amt_l;
  logic [DATA_W-1:0] w_s1;
  logic [DATA_W-1:0] w_s2;

  // A right rotate by n is a left rotate by (8 - n) mod 8, so one left rotator serves both.
  assign w_amt_l = lr ? amt : (~amt + 3'd1);

  assign w_s1 = w_amt_l[0] ? {a[6:0], a[7]}       : a;
  assign w_s2 = w_amt_l[1] ? {w_s1[5:0], w_s1[7:6]} : w_s1;
  assign y    = w_amt_l[2] ? {w_s2[3:0], w_s2[7:4]} : w_s2;

endmodule

// File: rtl/shift_arbiter_2ch.sv
// Round-robin arbiter sequencing two requesters through one shared rotating shifter.
// Optional grant counters enabled by defining SHARB_STATS_EN.
module shift_arbiter_2ch
  import shift_arb_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_lr,
  input  logic [AMT_W-1:0]  req0_amt,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_lr,
  input  logic [AMT_W-1:0]  req1_amt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ID_W-1:0]   out_id,
  output logic              busy
`ifdef SHARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1
`endif
);

  arb_state_t r_state;
  arb_state_t w_state_nxt;

  logic [ID_W-1:0]   r_ptr;
  logic [DATA_W-1:0] r_op_data;
  logic              r_op_lr;
  logic [AMT_W-1:0]  r_op_amt;
  logic [ID_W-1:0]   r_op_id;

  logic              w_grant_vld;
  logic [ID_W-1:0]   w_grant_id;
  logic              w_accept;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_sel_lr;
  logic [AMT_W-1:0]  w_sel_amt;
  logic [DATA_W-1:0] w_shift_y;

  // r_ptr holds the last requester served; on a tie the other one wins.
  always_comb begin
    w_grant_vld = req0_valid | req1_valid;
    w_grant_id  = '0;
    if (req0_valid && req1_valid) begin
      w_grant_id = ~r_ptr;
    end else if (req1_valid) begin
      w_grant_id = 1'b1;
    end
  end

  assign w_sel_data = w_grant_id[0] ? req1_data : req0_data;
  assign w_sel_lr   = w_grant_id[0] ? req1_lr   : req0_lr;
  assign w_sel_amt  = w_grant_id[0] ? req1_amt  : req0_amt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant_vld) begin
          w_accept    = 1'b1;
          req0_ready  = (w_grant_id == 1'b0);
          req1_ready  = (w_grant_id == 1'b1);
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: w_state_nxt = HOLD;
      HOLD: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign busy = (r_state != IDLE);

  // The shifter only ever sees the latched operands, never the live request inputs.
  barrel_shifter_lr_8b u_shifter (
    .a   (r_op_data),
    .lr  (r_op_lr),
    .amt (r_op_amt),
    .y   (w_shift_y)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op_data <= '0;
      r_op_lr   <= 1'b0;
      r_op_amt  <= '0;
      r_op_id   <= '0;
      r_ptr     <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
    end else begin
      if (w_accept) begin
        r_op_data <= w_sel_data;
        r_op_lr   <= w_sel_lr;
        r_op_amt  <= w_sel_amt;
        r_op_id   <= w_grant_id;
      end
      if (r_state == SHIFT) begin
        out_data  <= w_shift_y;
        out_id    <= r_op_id;
        out_valid <= 1'b1;
      end
      if ((r_state == HOLD) && out_ready) begin
        out_valid <= 1'b0;
        r_ptr     <= out_id;
      end
    end
  end

`ifdef SHARB_STATS_EN
  logic [CNT_W-1:0] r_grant_cnt0;
  logic [CNT_W-1:0] r_grant_cnt1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grant_cnt0 <= '0;
      r_grant_cnt1 <= '0;
    end else begin
      if (req0_ready && req0_valid) r_grant_cnt0 <= r_grant_cnt0 + 1'b1;
      if (req1_ready && req1_valid) r_grant_cnt1 <= r_grant_cnt1 + 1'b1;
    end
  end

  assign grant_cnt0 = r_grant_cnt0;
  assign grant_cnt1 = r_grant_cnt1;
`endif

endmodule

// File: tb/tb_shift_arbiter_2ch.sv
// Self-checking bench for shift_arbiter_2ch against a transaction-level reference model.
module tb_shift_arbiter_2ch;

  localparam int unsigned TB_CNT_W = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req0_ready, req0_lr;
  logic [7:0] req0_data;
  logic [2:0] req0_amt;
  logic       req1_valid, req1_ready, req1_lr;
  logic [7:0] req1_data;
  logic [2:0] req1_amt;
  logic       out_valid, out_ready;
  logic [7:0] out_data;
  logic [0:0] out_id;
  logic       busy;
`ifdef SHARB_STATS_EN
  logic [TB_CNT_W-1:0] grant_cnt0, grant_cnt1;
`endif

  always #5 clk = ~clk;

  shift_arbiter_2ch #(.CNT_W(TB_CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_lr    (req0_lr),
    .req0_amt   (req0_amt),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_lr    (req1_lr),
    .req1_amt   (req1_amt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_id     (out_id),
    .busy       (busy)
`ifdef SHARB_STATS_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: one operation in flight, its age, and what the output port shows.
  bit         m_busy;
  int         m_age;
  logic [7:0] m_res;
  logic       m_id;
  logic       m_last;
  logic [7:0] m_shown_data;
  logic       m_shown_id;
  int         m_cnt0, m_cnt1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rot(input logic [7:0] d, input logic lr, input logic [2:0] a);
    int x, n;
    x = d;
    n = a;
    if (n == 0) return d;
    if (lr) return 8'(((x << n) | (x >> (8 - n))) & 255);
    return 8'(((x >> n) | (x << (8 - n))) & 255);
  endfunction

  task automatic model_reset();
    m_busy       = 0;
    m_age        = 0;
    m_res        = 8'h00;
    m_id         = 1'b0;
    m_last       = 1'b1;
    m_shown_data = 8'h00;
    m_shown_id   = 1'b0;
    m_cnt0       = 0;
    m_cnt1       = 0;
  endtask

  task automatic check_counters();
`ifdef SHARB_STATS_EN
    check_eq("grant_cnt0", 32'(grant_cnt0), 32'(m_cnt0 % (1 << TB_CNT_W)));
    check_eq("grant_cnt1", 32'(grant_cnt1), 32'(m_cnt1 % (1 << TB_CNT_W)));
`endif
  endtask

  task automatic apply_cycle(input logic v0, input logic [7:0] d0, input logic lr0, input logic [2:0] a0,
                             input logic v1, input logic [7:0] d1, input logic lr1, input logic [2:0] a1,
                             input logic ordy);
    logic accept;
    logic gid;
    @(negedge clk);
    req0_valid = v0; req0_data = d0; req0_lr = lr0; req0_amt = a0;
    req1_valid = v1; req1_data = d1; req1_lr = lr1; req1_amt = a1;
    out_ready  = ordy;
    #1;
    accept = 1'b0;
    gid    = 1'b0;
    if (!m_busy && (v0 || v1)) begin
      accept = 1'b1;
      gid    = (v0 && v1) ? !m_last : v1;
    end
    check_eq("req0_ready", 32'(req0_ready), 32'(accept && !gid));
    check_eq("req1_ready", 32'(req1_ready), 32'(accept && gid));
    check_eq("busy",       32'(busy),       32'(m_busy));
    check_eq("out_valid",  32'(out_valid),  32'(m_busy && m_age >= 1));
    check_eq("out_data",   32'(out_data),   32'(m_shown_data));
    check_eq("out_id",     32'(out_id),     32'(m_shown_id));
    check_counters();
    @(posedge clk);
    if (accept) begin
      m_busy = 1;
      m_age  = 0;
      m_id   = gid;
      m_res  = gid ? rot(d1, lr1, a1) : rot(d0, lr0, a0);
      if (gid) m_cnt1++; else m_cnt0++;
    end else if (m_busy) begin
      if (m_age == 0) begin
        m_age        = 1;
        m_shown_data = m_res;
        m_shown_id   = m_id;
      end else if (ordy) begin
        m_busy = 0;
        m_last = m_id;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) apply_cycle(0, 8'h00, 0, 3'd0, 0, 8'h00, 0, 3'd0, 1);
  endtask

  task automatic check_reset_values();
    check_eq("rst_out_valid", 32'(out_valid),  32'(0));
    check_eq("rst_busy",      32'(busy),       32'(0));
    check_eq("rst_out_data",  32'(out_data),   32'(8'h00));
    check_eq("rst_out_id",    32'(out_id),     32'(0));
    check_eq("rst_req0_rdy",  32'(req0_ready), 32'(0));
    check_eq("rst_req1_rdy",  32'(req1_ready), 32'(0));
    check_counters();
  endtask

  // Asynchronous reset pulse in the low phase; valids are dropped so nothing is accepted meanwhile.
  task automatic reset_pulse();
    @(negedge clk);
    req0_valid = 0;
    req1_valid = 0;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_reset_values();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 0; req0_data = '0; req0_lr = 0; req0_amt = '0;
    req1_valid = 0; req1_data = '0; req1_lr = 0; req1_amt = '0;
    out_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_reset_values();
    #1;
    reset = 1'b0;

    // Single request from req0, then right rotate from req1, then amt = 0.
    apply_cycle(1, 8'h81, 1, 3'd1, 0, 8'h00, 0, 3'd0, 1);
    idle_cycles(3);
    apply_cycle(0, 8'h00, 0, 3'd0, 1, 8'h81, 0, 3'd3, 1);
    idle_cycles(3);
    apply_cycle(1, 8'hA5, 0, 3'd0, 0, 8'h00, 0, 3'd0, 1);
    idle_cycles(3);

    // Tie with both valid continuously.
    reset_pulse();
    for (int i = 0; i < 10; i++) apply_cycle(1, 8'h01, 1, 3'd2, 1, 8'h80, 0, 3'd7, 1);
    idle_cycles(2);

    // Back-pressure in HOLD with both requesters pushing.
    apply_cycle(1, 8'h3C, 1, 3'd4, 1, 8'hC3, 0, 3'd1, 0);
    for (int i = 0; i < 6; i++) apply_cycle(1, 8'h11, 0, 3'd5, 1, 8'h22, 1, 3'd6, 0);
    for (int i = 0; i < 4; i++) apply_cycle(0, 8'h00, 0, 3'd0, 0, 8'h00, 0, 3'd0, 1);

    // Reset in SHIFT, then a tie must go to req0.
    apply_cycle(0, 8'h00, 0, 3'd0, 1, 8'h5A, 1, 3'd3, 1);
    reset_pulse();
    for (int i = 0; i < 4; i++) apply_cycle(1, 8'h0F, 1, 3'd1, 1, 8'hF0, 0, 3'd2, 1);
    idle_cycles(2);

    // Randomised traffic with random back-pressure.
    for (int i = 0; i < 800; i++) begin
      apply_cycle(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom), 3'($urandom),
                  1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom), 3'($urandom),
                  1'($urandom_range(0, 99) < 70));
      if (i == 400) reset_pulse();
    end
    idle_cycles(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
